// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: datapath width, status bit positions,
// occupancy state encodings and the buffered {result,status} entry.
package alu_result_stage_pkg;

  localparam int WIDTH = 16;

  localparam int ST_NEG      = 3;
  localparam int ST_ZERO     = 2;
  localparam int ST_CARRY    = 1;
  localparam int ST_OVERFLOW = 0;

  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_ONE   = 2'd1,
    RS_FULL  = 2'd2
  } rs_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       status;
  } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream ALU-result and downstream writeback handshakes of the result stage.
// master drives results and consumes entries; slave is the result stage itself.
interface alu_result_stage_if;
  import alu_result_stage_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [3:0]       in_status;
  logic             in_flag_we;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_status;

  modport master (
    output in_valid, in_result, in_status, in_flag_we, out_ready,
    input  in_ready, out_valid, out_result, out_status
  );

  modport slave (
    input  in_valid, in_result, in_status, in_flag_we, out_ready,
    output in_ready, out_valid, out_result, out_status
  );

endinterface

// File: rtl/alu_skid_buf.sv
// 2-entry {result,status} FIFO with occupancy FSM; push visible at output next cycle.
// in_rdy_o drops only when FULL and is registered, so it never depends on pop_i in the same cycle.
module alu_skid_buf
  import alu_result_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t in_dat_i,
  output logic   in_rdy_o,
  output logic   out_vld_o,
  output entry_t out_dat_o
);

  rs_state_e state_q;
  entry_t    head_q;
  entry_t    tail_q;
  logic      out_vld_q;
  logic      in_rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RS_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      case (state_q)
        RS_EMPTY: begin
          if (push_i) begin
            head_q    <= in_dat_i;
            state_q   <= RS_ONE;
            out_vld_q <= 1'b1;
          end
        end
        RS_ONE: begin
          case ({push_i, pop_i})
            2'b10: begin
              tail_q   <= in_dat_i;
              state_q  <= RS_FULL;
              in_rdy_q <= 1'b0;
            end
            2'b01: begin
              state_q   <= RS_EMPTY;
              out_vld_q <= 1'b0;
            end
            // Head leaves and the new entry takes its place in one cycle.
            2'b11:   head_q <= in_dat_i;
            default: ;
          endcase
        end
        RS_FULL: begin
          if (pop_i) begin
            head_q   <= tail_q;
            state_q  <= RS_ONE;
            in_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= RS_EMPTY;
          out_vld_q <= 1'b0;
          in_rdy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_rdy_o  = in_rdy_q;
  assign out_vld_o = out_vld_q;
  assign out_dat_o = head_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: skid-buffers result/status (1-cycle latency) and keeps flags/sticky overflow.
// Upstream stalls only when both buffer entries are held by a stalled writeback consumer.
module alu_result_stage
  import alu_result_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus,
  input  logic                clr_sticky_i,
  output logic [3:0]          flags_o,
  output logic                sticky_ovf_o
);

  logic       push;
  logic       pop;
  entry_t     in_dat;
  entry_t     out_dat;
  logic       in_rdy;
  logic       out_vld;
  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       sticky_q;
  logic       sticky_d;

  assign push   = bus.in_valid & in_rdy;
  assign pop    = out_vld & bus.out_ready;
  assign in_dat = '{result: bus.in_result, status: bus.in_status};

  alu_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .in_dat_i  (in_dat),
    .in_rdy_o  (in_rdy),
    .out_vld_o (out_vld),
    .out_dat_o (out_dat)
  );

  // Flags track accepted ops, not consumed ones; a set beats a same-cycle clear.
  always_comb begin
    flags_d  = flags_q;
    sticky_d = sticky_q & ~clr_sticky_i;
    if (push && bus.in_flag_we) begin
      flags_d = bus.in_status;
      if (bus.in_status[ST_OVERFLOW]) sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_result = out_dat.result;
  assign bus.out_status = out_dat.status;
  assign flags_o        = flags_q;
  assign sticky_ovf_o   = sticky_q;

endmodule
